// File: rtl/gemm_accelerator_multi_lane_if.sv
// SRAM-side bundle of the multi-lane GeMM engine: A/B read ports and the lane-wide C write port.
interface gemm_accelerator_multi_lane_if #(
    parameter int unsigned InDataWidth  = 8,
    parameter int unsigned OutDataWidth = 32,
    parameter int unsigned AddrWidth    = 12,
    parameter int unsigned NumLanes     = 4
);
    logic [AddrWidth-1:0]             sram_a_addr_o;
    logic [AddrWidth-1:0]             sram_b_addr_o;
    logic [AddrWidth-1:0]             sram_c_addr_o;
    logic [InDataWidth-1:0]           sram_a_rdata_i;
    logic [NumLanes*InDataWidth-1:0]  sram_b_rdata_i;
    logic [NumLanes*OutDataWidth-1:0] sram_c_wdata_o;
    logic [NumLanes-1:0]              sram_c_we_o;

    modport master (
        output sram_a_addr_o, sram_b_addr_o, sram_c_addr_o, sram_c_wdata_o, sram_c_we_o,
        input  sram_a_rdata_i, sram_b_rdata_i
    );

    modport slave (
        input  sram_a_addr_o, sram_b_addr_o, sram_c_addr_o, sram_c_wdata_o, sram_c_we_o,
        output sram_a_rdata_i, sram_b_rdata_i
    );
endinterface

// File: rtl/gemm_accelerator_multi_lane.sv
// Multi-lane GeMM engine: C = A x B with NumLanes MAC lanes across N, one (m,nb,k) step per cycle.
// Optional macro GEMM_SAT_ACC_EN: saturating lane accumulators plus a sticky sat_o flag.

module gemm_mac_lane #(
    parameter int unsigned InDataWidth  = 8,
    parameter int unsigned OutDataWidth = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          en_i,
    input  logic                          first_i,
    input  logic signed [InDataWidth-1:0] a_i,
    input  logic signed [InDataWidth-1:0] b_i,
    output logic [OutDataWidth-1:0]       acc_o
`ifdef GEMM_SAT_ACC_EN
    ,
    output logic                          sat_o
`endif
);
    localparam int unsigned PW = 2 * InDataWidth;

    logic signed [PW-1:0]           prod;
    logic signed [OutDataWidth-1:0] prod_ext;
    logic signed [OutDataWidth-1:0] base;
    logic signed [OutDataWidth-1:0] acc_q;
    logic signed [OutDataWidth-1:0] acc_d;

    assign prod     = PW'(a_i) * PW'(b_i);
    assign prod_ext = OutDataWidth'(prod);
    // k==0 restarts the block instead of adding to the previous block's result
    assign base     = first_i ? '0 : acc_q;

`ifdef GEMM_SAT_ACC_EN
    logic signed [OutDataWidth:0] sum;
    logic                         ovf;

    assign sum = (OutDataWidth+1)'(base) + (OutDataWidth+1)'(prod_ext);
    assign ovf = sum[OutDataWidth] ^ sum[OutDataWidth-1];

    always_comb begin
        acc_d = sum[OutDataWidth-1:0];
        if (ovf) acc_d = sum[OutDataWidth] ? {1'b1, {(OutDataWidth-1){1'b0}}}
                                           : {1'b0, {(OutDataWidth-1){1'b1}}};
    end

    assign sat_o = en_i & ovf;
`else
    assign acc_d = base + prod_ext;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)   acc_q <= '0;
        else if (en_i) acc_q <= acc_d;
    end

    assign acc_o = acc_q;
endmodule

module gemm_accelerator_multi_lane #(
    parameter int unsigned InDataWidth   = 8,
    parameter int unsigned OutDataWidth  = 32,
    parameter int unsigned AddrWidth     = 12,
    parameter int unsigned SizeAddrWidth = 8,
    parameter int unsigned NumLanes      = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic [SizeAddrWidth-1:0]     M_size_i,
    input  logic [SizeAddrWidth-1:0]     K_size_i,
    input  logic [SizeAddrWidth-1:0]     N_size_i,
    gemm_accelerator_multi_lane_if.master sram,
    output logic                         busy_o,
    output logic                         done_o
`ifdef GEMM_SAT_ACC_EN
    ,
    output logic                         sat_o
`endif
);
    localparam int unsigned LaneShift = $clog2(NumLanes);
    localparam int unsigned STAGES    = 2;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_e;

    typedef struct packed {
        logic                 last;
        logic [AddrWidth-1:0] c_addr;
        logic [NumLanes-1:0]  mask;
    } blk_tag_t;

    state_e state_q, state_d;
    logic   drain_q;

    logic [SizeAddrWidth-1:0] m_sz, k_sz, n_sz, nb_sz;
    logic [SizeAddrWidth-1:0] m_cnt, k_cnt, nb_cnt, n_left;
    logic [SizeAddrWidth:0]   n_round;
    logic [SizeAddrWidth-1:0] nb_in;
    logic [AddrWidth-1:0]     a_addr, a_row, b_addr, c_addr;
    logic                     last_k, last_nb, last_m, size_zero;

    logic [STAGES:0] vld_pipe;
    blk_tag_t        tag_issue, tag_d, tag_w;
    logic            first_d;
    logic            wr_en;

    logic [NumLanes-1:0][InDataWidth-1:0]  b_lanes;
    logic [NumLanes-1:0][OutDataWidth-1:0] acc_lanes;

    assign n_round   = {1'b0, N_size_i} + (SizeAddrWidth+1)'(NumLanes - 1);
    assign nb_in     = SizeAddrWidth'(n_round >> LaneShift);
    assign size_zero = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);

    assign last_k  = (k_cnt  == k_sz  - SizeAddrWidth'(1));
    assign last_nb = (nb_cnt == nb_sz - SizeAddrWidth'(1));
    assign last_m  = (m_cnt  == m_sz  - SizeAddrWidth'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = size_zero ? DONE : RUN;
            RUN:     if (last_k && last_nb && last_m) state_d = DRAIN;
            DRAIN:   if (drain_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Loop counters and incrementally maintained addresses (no multipliers on the address path)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_sz   <= '0;
            k_sz   <= '0;
            n_sz   <= '0;
            nb_sz  <= '0;
            m_cnt  <= '0;
            k_cnt  <= '0;
            nb_cnt <= '0;
            n_left <= '0;
            a_addr <= '0;
            a_row  <= '0;
            b_addr <= '0;
            c_addr <= '0;
        end else if (state_q == IDLE) begin
            if (start_i) begin
                m_sz   <= M_size_i;
                k_sz   <= K_size_i;
                n_sz   <= N_size_i;
                nb_sz  <= nb_in;
                m_cnt  <= '0;
                k_cnt  <= '0;
                nb_cnt <= '0;
                n_left <= N_size_i;
                a_addr <= '0;
                a_row  <= '0;
                b_addr <= '0;
                c_addr <= '0;
            end
        end else if (state_q == RUN) begin
            if (!last_k) begin
                k_cnt  <= k_cnt + SizeAddrWidth'(1);
                a_addr <= a_addr + AddrWidth'(1);
                b_addr <= b_addr + AddrWidth'(nb_sz);
            end else begin
                k_cnt  <= '0;
                c_addr <= c_addr + AddrWidth'(1);
                if (!last_nb) begin
                    nb_cnt <= nb_cnt + SizeAddrWidth'(1);
                    n_left <= n_left - SizeAddrWidth'(NumLanes);
                    a_addr <= a_row;
                    b_addr <= AddrWidth'(nb_cnt) + AddrWidth'(1);
                end else begin
                    nb_cnt <= '0;
                    n_left <= n_sz;
                    m_cnt  <= m_cnt + SizeAddrWidth'(1);
                    a_addr <= a_addr + AddrWidth'(1);
                    a_row  <= a_addr + AddrWidth'(1);
                    b_addr <= '0;
                end
            end
        end
    end

    always_comb begin
        tag_issue        = '0;
        tag_issue.last   = last_k;
        tag_issue.c_addr = c_addr;
        for (int l = 0; l < NumLanes; l++) tag_issue.mask[l] = (32'(n_left) > l);
    end

    // vld_pipe[0]: issue, [1]: data/MAC, [2]: C write
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe <= '0;
            drain_q  <= 1'b0;
            tag_d    <= '0;
            tag_w    <= '0;
            first_d  <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], state_d == RUN};
            drain_q  <= (state_q == DRAIN) && !drain_q;
            tag_d    <= tag_issue;
            tag_w    <= tag_d;
            first_d  <= (k_cnt == '0);
        end
    end

    assign b_lanes = sram.sram_b_rdata_i;

`ifdef GEMM_SAT_ACC_EN
    logic [NumLanes-1:0] lane_sat;
    logic                sat_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                             sat_q <= 1'b0;
        else if (state_q == IDLE && start_i)     sat_q <= 1'b0;
        else if (|(lane_sat & tag_d.mask))       sat_q <= 1'b1;
    end

    assign sat_o = sat_q;
`endif

    for (genvar l = 0; l < NumLanes; l++) begin : g_lane
        gemm_mac_lane #(
            .InDataWidth (InDataWidth),
            .OutDataWidth(OutDataWidth)
        ) u_lane (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .en_i   (vld_pipe[1]),
            .first_i(first_d),
            .a_i    (sram.sram_a_rdata_i),
            .b_i    (b_lanes[l]),
            .acc_o  (acc_lanes[l])
`ifdef GEMM_SAT_ACC_EN
            ,
            .sat_o  (lane_sat[l])
`endif
        );
    end

    // The accumulators still hold the finished block during the write cycle,
    // even when the next block's k==0 MAC lands in the same cycle.
    assign wr_en = vld_pipe[2] & tag_w.last;

    assign sram.sram_a_addr_o  = vld_pipe[0] ? a_addr : '0;
    assign sram.sram_b_addr_o  = vld_pipe[0] ? b_addr : '0;
    assign sram.sram_c_addr_o  = wr_en ? tag_w.c_addr : '0;
    assign sram.sram_c_we_o    = wr_en ? tag_w.mask : '0;
    assign sram.sram_c_wdata_o = wr_en ? acc_lanes : '0;

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);
endmodule

// File: doc/gemm_accelerator_multi_lane.md
Name: gemm_accelerator_multi_lane

Overview:
Next-generation GeMM engine computing C = A x B for signed integer matrices, with NumLanes parallel MAC lanes working across the N dimension.
- Reads one A element and one NumLanes-wide B word per cycle.
- Writes one NumLanes-wide C word per output block.
- Sits between the three single-port SRAMs (A, B read-only; C write-only) and the system start/done control. It replaces the one-MAC top-level.

Parameters:
InDataWidth, 8, width of signed A/B elements
OutDataWidth, 32, width of signed C elements and accumulators
AddrWidth, 12, SRAM word address width
SizeAddrWidth, 8, width of M/K/N size inputs
NumLanes, 4, parallel MAC lanes (power of two, >=1)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  start request, sampled in IDLE only
M_size_i  in  SizeAddrWidth  rows of A/C
K_size_i  in  SizeAddrWidth  inner dimension
N_size_i  in  SizeAddrWidth  columns of B/C
sram_a_addr_o  out  AddrWidth  A word address
sram_b_addr_o  out  AddrWidth  B wide-word address
sram_c_addr_o  out  AddrWidth  C wide-word address
sram_a_rdata_i  in  InDataWidth  A data, valid 1 cycle after address
sram_b_rdata_i  in  NumLanes*InDataWidth  B data (lane l at bits [l*InDataWidth +: InDataWidth]), valid 1 cycle after address
sram_c_wdata_o  out  NumLanes*OutDataWidth  C write data, lane-packed the same way
sram_c_we_o  out  NumLanes  per-lane write enable
busy_o  out  1  high outside IDLE
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0. FSM returns to IDLE. Counters and accumulators are cleared. Reset mid-operation aborts with no further writes.
- Memory layout: NB = ceil(N/NumLanes).
  - A(m,k) is at address m*K+k.
  - B word k*NB+nb, lane l, holds B(k, nb*NumLanes+l).
  - C word m*NB+nb, lane l, holds C(m, nb*NumLanes+l).
- Start handshake:
  - In IDLE, start_i=1 at a clock edge latches M/K/N and moves to RUN, or directly to DONE if any size is 0.
  - start_i in any other state is ignored.
  - Size inputs may change after the start edge without effect.
- States and transitions: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- RUN: one (m,nb,k) address triple per cycle, loop order m outer, nb middle, k inner. No bubbles. T = M*NB*K cycles in total.
- Pipeline:
  - Cycle c: addresses issued.
  - Cycle c+1: data arrives and lanes MAC. acc_l = prod_l when k==0, else acc_l + prod_l.
  - Products are full-precision signed (2*InDataWidth), sign-extended to OutDataWidth.
  - Accumulation wraps modulo 2^OutDataWidth.
- Write: in the cycle after the k==K-1 MAC, C is written.
  - sram_c_we_o = lane mask; lane l is enabled iff nb*NumLanes+l < N.
  - sram_c_addr_o = m*NB+nb.
  - wdata = accumulators.
  - The next block's k==0 MAC may occur in the same cycle.
- K=1: one write every cycle. That is legal.
- DRAIN: two cycles to flush the data and write stages.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Timing: with the first RUN cycle as 0, the last write is in cycle T+1 and done_o is in cycle T+2.
- Idle outputs: addresses and sram_c_wdata_o hold 0 when not issuing or writing. sram_c_we_o=0 except in write cycles.
- Address arithmetic is modulo 2^AddrWidth. Callers must keep matrices within DataDepth.

Optional Feature:
GEMM_SAT_ACC_EN:
- Defined: each lane accumulator saturates to [-2^(OutDataWidth-1), 2^(OutDataWidth-1)-1] on every add, and a sticky sat_o output (1 bit, cleared at start) flags any saturation.
- Undefined: wrap-around arithmetic and no sat_o port.

Test Plan:
- M=K=N=4, NumLanes=4, A=identity, B(k,n)=k*4+n -> one write per row, C equals B, done_o at cycle 4*1*4+2=18 after the first RUN cycle.
- M=2, K=3, N=6 (NB=2), random signed data -> 4 writes; the second block of each row has we=4'b0011; C matches the golden model; the upper lanes of C are untouched.
- A all -128, B all -128, K=255, M=N=1 -> C(0,0)=4177920, we=4'b0001.
- Any size 0 -> no sram_c_we_o activity; done_o pulses 2 cycles after the start edge (IDLE, DONE).
- start_i held high during RUN with M=K=N=8 -> ignored, single done pulse; rst_ni low mid-RUN -> all outputs 0 asynchronously, no further writes, a new start works.
- With GEMM_SAT_ACC_EN, A=127, B=127, K=255, OutDataWidth=16 -> C=32767, sat_o=1.
